// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache controller.
//   - Geometry constants (LINES, TAG_W, DATA_W, IDX_W)
//   - Controller state encoding
//   - Address helpers: tag extraction and line-aligned address
package dcache_pkg;

  localparam int LINES  = 16;
  localparam int TAG_W  = 29;
  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(LINES);

  typedef enum logic [1:0] {
    IDLE,
    MEM_RD,
    MEM_WR,
    DONE
  } state_e;

  // Tag is the word address above the 8-byte line offset.
  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] addr);
    return TAG_W'(addr >> 3);
  endfunction

  // Address presented to backing memory: offset bits cleared.
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return addr & ~32'h7;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Request/ack handshake between the cache controller and backing memory.
//   req   : request, held until ack
//   we    : 1 = write, 0 = read (valid while req is high)
//   addr  : line-aligned address
//   wdata : store data
//   ack   : one-cycle completion pulse
//   rdata : refill data, valid in the ack cycle
interface dcache_if;
  import dcache_pkg::*;

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/dcache_victim_sel.sv
// Replacement victim selection.
//   valid   : per-line valid bits
//   rr_ptr  : current round-robin pointer
//   victim  : lowest-index invalid line, else rr_ptr
//   use_rr  : 1 when the victim came from rr_ptr (pointer must advance)
//   rr_next : rr_ptr + 1, wrapping at LINES
module dcache_victim_sel
  import dcache_pkg::*;
(
  input  logic [LINES-1:0] valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] victim,
  output logic             use_rr,
  output logic [IDX_W-1:0] rr_next
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    victim = rr_ptr;
    use_rr = 1'b1;
    // Scan downward so the lowest invalid index wins.
    for (int i = LINES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim = IDX_W'(i);
        use_rr = 1'b0;
      end
    end
  end

  // LINES is a power of two, so the natural overflow wraps 15 -> 0.
  assign rr_next = rr_ptr + IDX_W'(1);

endmodule

// File: rtl/dcache_controller.sv
// Sequencing controller for a fully associative, write-through,
// no-write-allocate, read-allocate data cache.
//   clk, reset          : clock, synchronous active-high reset
//   cpu_*               : processor load/store port, cpu_stall holds it
//   arr_*               : data array index/write port, async read data
//   mem                 : request/ack handshake to backing memory
//   hit_cnt, miss_cnt   : saturating access statistics
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [IDX_W-1:0]  arr_idx,
  output logic              arr_we,
  output logic [DATA_W-1:0] arr_wdata,
  input  logic [DATA_W-1:0] arr_rdata,
  dcache_if.master          mem,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [IDX_W-1:0]  rr_ptr_q, rr_next, victim;
  logic              use_rr;
  logic [DATA_W-1:0] fill_q;
  logic              wr_hit_q;
  logic [IDX_W-1:0]  wr_idx_q;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              cnt_hit, cnt_miss, refill, capture;

  dcache_victim_sel u_victim (
    .valid   (valid_q),
    .rr_ptr  (rr_ptr_q),
    .victim  (victim),
    .use_rr  (use_rr),
    .rr_next (rr_next)
  );

  // Tag match; at most one line can match since lines are only allocated
  // on a miss.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < LINES; i++) begin
      if (valid_q[i] && tag_q[i] == tag_of(cpu_addr)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    cpu_rdata = arr_rdata;
    arr_idx   = hit_idx;
    arr_we    = 1'b0;
    arr_wdata = mem.rdata;
    mem.req   = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = line_addr(cpu_addr);
    mem.wdata = cpu_wdata;
    cnt_hit   = 1'b0;
    cnt_miss  = 1'b0;
    refill    = 1'b0;
    capture   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A combined read+write takes the write path.
        if (cpu_write) begin
          cpu_stall = 1'b1;
          capture   = 1'b1;
          cnt_hit   = hit;
          cnt_miss  = !hit;
          state_d   = MEM_WR;
        end else if (cpu_read) begin
          if (hit) begin
            cnt_hit = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            cnt_miss  = 1'b1;
            state_d   = MEM_RD;
          end
        end
      end
      MEM_RD: begin
        mem.req   = 1'b1;
        cpu_stall = 1'b1;
        arr_idx   = victim;
        if (mem.ack) begin
          arr_we  = 1'b1;
          refill  = 1'b1;
          state_d = DONE;
        end
      end
      MEM_WR: begin
        mem.req   = 1'b1;
        mem.we    = 1'b1;
        cpu_stall = 1'b1;
        arr_idx   = wr_idx_q;
        arr_wdata = cpu_wdata;
        if (mem.ack) begin
          arr_we  = wr_hit_q;
          state_d = DONE;
        end
      end
      DONE: begin
        cpu_rdata = fill_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      rr_ptr_q <= '0;
      fill_q   <= '0;
      wr_hit_q <= 1'b0;
      wr_idx_q <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      // NOTE: the tag store is small flop storage, so it is cleared here;
      // valid bits alone would suffice for correctness.
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        wr_hit_q <= hit;
        wr_idx_q <= hit_idx;
      end
      if (refill) begin
        valid_q[victim] <= 1'b1;
        tag_q[victim]   <= tag_of(cpu_addr);
        fill_q          <= mem.rdata;
        if (use_rr) rr_ptr_q <= rr_next;
      end
      if (cnt_hit && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
      if (cnt_miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller. The model tracks which lines
// are cached (slot contents, fill order) and the backing-memory contents;
// every load must return the backing-memory value of its line.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_read = 1'b0;
  logic              cpu_write = 1'b0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic [IDX_W-1:0]  arr_idx;
  logic              arr_we;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [15:0]       hit_cnt, miss_cnt;

  dcache_if mem_bus ();

  dcache_controller dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .arr_idx   (arr_idx),
    .arr_we    (arr_we),
    .arr_wdata (arr_wdata),
    .arr_rdata (arr_rdata),
    .mem       (mem_bus),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  // Data array: asynchronous read, synchronous write.
  logic [DATA_W-1:0] arr_mem [LINES];
  always @(posedge clk) if (arr_we) arr_mem[arr_idx] <= arr_wdata;
  assign arr_rdata = arr_mem[arr_idx];

  // Reference model.
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  int          m_rr;
  logic [31:0] backing [logic [31:0]];
  int          exp_hits, exp_misses;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = '0;
    end
    m_rr       = 0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; mem_bus.ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    check("rst_req", mem_bus.req, 1'b0);
    check("rst_we", mem_bus.we, 1'b0);
    check("rst_arr_we", arr_we, 1'b0);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
  endtask

  // One processor access; ack arrives on MEM cycle number 'delay' (0-based).
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay);
    logic [31:0] line;
    bit          hit;
    int          slot, victim;
    bit          from_rr;
    line = {addr[31:3], 3'b000};
    hit  = 1'b0;
    slot = 0;
    for (int i = 0; i < LINES; i++)
      if (m_valid[i] && m_line[i] == line) begin hit = 1'b1; slot = i; end
    if (!backing.exists(line)) backing[line] = $urandom;
    victim  = m_rr;
    from_rr = 1'b1;
    for (int i = LINES - 1; i >= 0; i--)
      if (!m_valid[i]) begin victim = i; from_rr = 1'b0; end

    @(negedge clk);
    cpu_addr = addr; cpu_wdata = wdata; cpu_read = rd; cpu_write = wr;
    #1;
    if (!wr && hit) begin
      check("hit_stall", cpu_stall, 1'b0);
      check("hit_idx", arr_idx, slot);
      check("hit_rdata", cpu_rdata, backing[line]);
      check("hit_req", mem_bus.req, 1'b0);
      exp_hits++;
    end else begin
      check("acc_stall", cpu_stall, 1'b1);
      if (hit) exp_hits++; else exp_misses++;
      for (int n = 0; n <= delay; n++) begin
        @(negedge clk);
        if (n == delay) begin
          mem_bus.ack   = 1'b1;
          mem_bus.rdata = wr ? $urandom : backing[line];
        end
        #1;
        check("mem_req", mem_bus.req, 1'b1);
        check("mem_we", mem_bus.we, wr);
        check("mem_addr", mem_bus.addr, line);
        if (wr) check("mem_wdata", mem_bus.wdata, wdata);
        check("busy_stall", cpu_stall, 1'b1);
        if (n < delay) check("wait_arr_we", arr_we, 1'b0);
        else if (wr) begin
          check("wr_arr_we", arr_we, hit);
          if (hit) begin
            check("wr_arr_idx", arr_idx, slot);
            check("wr_arr_wdata", arr_wdata, wdata);
          end
        end else begin
          check("fill_arr_we", arr_we, 1'b1);
          check("fill_arr_idx", arr_idx, victim);
          check("fill_arr_wdata", arr_wdata, backing[line]);
        end
      end
      @(negedge clk);
      mem_bus.ack = 1'b0;
      #1;
      check("done_stall", cpu_stall, 1'b0);
      check("done_req", mem_bus.req, 1'b0);
      if (!wr) check("done_rdata", cpu_rdata, backing[line]);
      cpu_read = 1'b0; cpu_write = 1'b0;
      if (wr) backing[line] = wdata;
      else begin
        m_valid[victim] = 1'b1;
        m_line[victim]  = line;
        if (from_rr) m_rr = (m_rr + 1) % LINES;
      end
    end
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0;
    #1;
    check("hit_cnt", hit_cnt, exp_hits);
    check("miss_cnt", miss_cnt, exp_misses);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_bus.ack   = 1'b0;
    mem_bus.rdata = '0;
    model_clear();
    reset_dut();

    // Cold read miss with ack on the third MEM_RD cycle, then a hit.
    backing[32'h0000_1010] = 32'hDEAD_BEEF;
    access(1'b1, 1'b0, 32'h0000_1010, '0, 2);
    access(1'b1, 1'b0, 32'h0000_1010, '0, 0);

    // Replacement: fill all lines, then evict round-robin.
    reset_dut();
    for (int i = 0; i < LINES; i++) access(1'b1, 1'b0, 32'h100 + 32'(i * 8), '0, i % 3);
    access(1'b1, 1'b0, 32'h200, '0, 0);
    access(1'b1, 1'b0, 32'h208, '0, 1);
    access(1'b1, 1'b0, 32'h100, '0, 0);

    // Write hit, read back; write miss, read misses.
    access(1'b1, 1'b0, 32'h0000_1010, '0, 0);
    access(1'b0, 1'b1, 32'h0000_1010, 32'h1234_5678, 1);
    access(1'b1, 1'b0, 32'h0000_1010, '0, 0);
    access(1'b0, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 0);
    access(1'b1, 1'b0, 32'h0000_2000, '0, 1);

    // Read and write together takes the write path.
    access(1'b1, 1'b1, 32'h0000_1010, 32'h0BAD_CAFE, 0);

    // Reset in the middle of a read miss.
    @(negedge clk);
    cpu_addr = 32'h0000_3000; cpu_read = 1'b1;
    #1;
    check("mid_stall", cpu_stall, 1'b1);
    @(negedge clk); #1;
    check("mid_req", mem_bus.req, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; cpu_read = 1'b0;
    model_clear();
    #1;
    check("mid_rst_req", mem_bus.req, 1'b0);
    check("mid_rst_stall", cpu_stall, 1'b0);
    check("mid_rst_hit_cnt", hit_cnt, 0);
    check("mid_rst_miss_cnt", miss_cnt, 0);
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'hBAD0_BAD0;
    #1;
    check("late_ack_arr_we", arr_we, 1'b0);
    @(negedge clk);
    mem_bus.ack = 1'b0;
    #1;
    check("late_ack_req", mem_bus.req, 1'b0);
    check("late_ack_stall", cpu_stall, 1'b0);
    access(1'b1, 1'b0, 32'h0000_1010, '0, 0);

    // Randomized traffic over more lines than the cache holds.
    for (int k = 0; k < 200; k++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      a  = 32'h0004_0000 + 32'($urandom_range(0, 23) * 8) + 32'($urandom_range(0, 7));
      access(op < 6 || op == 9, op >= 6, a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Sequencing controller for the processor's 16-line fully associative data cache (one 32-bit word per line, tag = address[31:3]). Holds the tag and valid store and the replacement pointer, and drives the data array through an index/write port. Stalls the processor on misses and writes, and runs a request/ack handshake to backing memory. Policy is write-through, no-write-allocate, read-allocate.

Parameters:
LINES, 16, number of cache lines (power of two)
TAG_W, 29, tag width, taken from address[31:3]
DATA_W, 32, word width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_addr  in  32  ALU result address
cpu_wdata  in  32  store data
cpu_read  in  1  MemRead
cpu_write  in  1  MemWrite
cpu_rdata  out  32  load data
cpu_stall  out  1  processor must hold its request while this is high
arr_idx  out  log2(LINES)  data array line index
arr_we  out  1  data array write enable
arr_wdata  out  32  data array write data
arr_rdata  in  32  data array asynchronous read data at arr_idx
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  32  {cpu_addr[31:3], 3'b000}
mem_wdata  out  32  cpu_wdata
mem_ack  in  1  one-cycle completion pulse; mem_rdata is valid in the same cycle
mem_rdata  in  32  refill data
hit_cnt  out  16  saturating count of hits
miss_cnt  out  16  saturating count of misses

Behaviour:
- Reset (synchronous): state IDLE; all valid bits 0; tags 0; rr_ptr 0; fill register 0; hit_cnt and miss_cnt 0. mem_req, mem_we and arr_we read 0 after the reset edge.
- Hit: some line i has valid[i] and tag[i] == cpu_addr[31:3]. The hit index is combinational. Duplicate tags cannot occur because allocation happens only on a miss.
- Simultaneous cpu_read and cpu_write: treated as a write.
- States:
  - IDLE
  - MEM_RD
  - MEM_WR
  - DONE
- IDLE, read hit: zero wait. cpu_stall = 0, arr_idx = hit index, cpu_rdata = arr_rdata in the same cycle. hit_cnt increments.
- IDLE, read miss: cpu_stall = 1 combinationally. Next state MEM_RD. miss_cnt increments.
- IDLE, write (hit or miss): cpu_stall = 1. Capture the hit flag and hit index. Next state MEM_WR. The matching hit_cnt or miss_cnt increments.
- Counters increment exactly once per access, in its IDLE cycle. Both saturate at 16'hFFFF.
- IDLE with no request: cpu_stall = 0, cpu_rdata = arr_rdata, no state change.
- MEM_RD: mem_req = 1, mem_we = 0, cpu_stall = 1. On mem_ack:
  - arr_we = 1, arr_idx = victim, arr_wdata = mem_rdata
  - set the victim's tag and valid bit; latch mem_rdata into the fill register
  - go to DONE
- MEM_WR: mem_req = 1, mem_we = 1, cpu_stall = 1. On mem_ack:
  - if the captured flag is a hit: arr_we = 1 at the captured index with cpu_wdata
  - on a miss the array is not touched
  - go to DONE
- DONE: cpu_stall = 0 for exactly one cycle; cpu_rdata = fill register (reads only). Then go to IDLE.
- Victim select: the lowest-index invalid line if any exists. Otherwise rr_ptr, and rr_ptr increments (wraps 15 -> 0) only when it supplied the victim.
- Latency: read miss = 1 (IDLE) + N (MEM_RD until ack) + 1 (DONE) cycles. Memory may ack as early as the first MEM_RD cycle.
- mem_ack outside MEM_RD or MEM_WR is ignored.
- The processor holds cpu_addr, cpu_wdata, cpu_read and cpu_write stable while cpu_stall is high. The controller samples cpu_wdata directly and does not register it.
- Reset mid-transaction abandons the request: mem_req drops after the reset edge, no array write occurs, all lines become invalid. A late mem_ack is ignored. Backing memory must tolerate a dropped request.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, MEM_RD, MEM_WR, DONE)
  - LINES, TAG_W, IDX_W constants
  - tag_of(addr) and line_addr(addr) functions
- Sub-module dcache_victim_sel: takes the valid vector and rr_ptr; returns the victim index and a use_rr flag. Priority encoder plus round-robin pointer update.

Test Plan:
- Cold read miss: after reset, read 0x0000_1010.
  - cpu_stall = 1 that cycle; next cycle mem_req = 1, mem_we = 0, mem_addr = 0x0000_1010.
  - ack on the 3rd MEM_RD cycle with 0xDEADBEEF: arr_we = 1 at idx 0.
  - DONE: cpu_rdata = 0xDEADBEEF, stall = 0; miss_cnt = 1.
- Read hit: repeat the read of 0x0000_1010.
  - cpu_stall = 0 and arr_idx = 0 in the same cycle; cpu_rdata = 0xDEADBEEF.
  - mem_req stays 0; hit_cnt = 1.
- Replacement: miss on 16 distinct lines (0x100, 0x108 ... 0x178).
  - They fill idx 0..15 in order.
  - A 17th miss (0x200) evicts idx 0; an 18th (0x208) evicts idx 1.
  - A re-read of 0x100 misses.
- Write hit, then write miss:
  - Write 0x12345678 to cached 0x1010: mem_we = 1, mem_wdata = 0x12345678; on ack arr_we = 1 at that line. A following read hits and returns 0x12345678.
  - Write to uncached 0x2000: memory write only, arr_we stays 0. A following read of 0x2000 misses.
- Reset mid-miss: assert reset while in MEM_RD with mem_req = 1.
  - Next cycle mem_req = 0 and state is IDLE; counters = 0.
  - A late mem_ack causes no arr_we; a read of the previously cached address misses.
- Read and write together: cpu_read = cpu_write = 1 at 0x1010 follows the write path (mem_we = 1) and increments hit_cnt once.
